mmio_ctrl: RTL and testbench



---
 rtl/mmio_pkg.sv | 18 +
 rtl/mmio_tx_buf.sv | 47 ++++
 rtl/mmio_ctrl.sv | 106 ++++++++++
 tb/tb_mmio_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets, STATUS bit positions and TX state encoding for mmio_ctrl
package mmio_pkg;
    localparam logic [7:0] OFF_STATUS    = 8'h00;
    localparam logic [7:0] OFF_RX_DATA   = 8'h04;
    localparam logic [7:0] OFF_TX_DATA   = 8'h08;
    localparam logic [7:0] OFF_CYCLE_CNT = 8'h10;
    localparam logic [7:0] OFF_INST_CNT  = 8'h14;
    localparam logic [7:0] OFF_CNT_RST   = 8'h18;

    localparam int ST_TX_READY = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_TX_OVF   = 2;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_PEND = 1'b1
    } tx_state_t;
endpackage

// File: rtl/mmio_tx_buf.sv
// mmio_tx_buf: one-entry UART TX holding buffer with sticky overflow flag
module mmio_tx_buf
    import mmio_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr,
    input  logic [7:0] i_wdata,
    input  logic       i_ovf_clr,
    input  logic       i_tx_ready,
    output logic       o_full,
    output logic       o_ovf,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data
);
    tx_state_t  r_state;
    logic       r_valid;
    logic       r_ovf;
    logic [7:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            // a fresh overflow wins over a STATUS read clearing the flag
            r_ovf <= (i_wr && r_state == TX_PEND) || (r_ovf && !i_ovf_clr);
            if (r_state == TX_IDLE) begin
                if (i_wr) begin
                    r_data  <= i_wdata;
                    r_state <= TX_PEND;
                    r_valid <= 1'b1;
                end
            end else if (i_tx_ready) begin
                r_state <= TX_IDLE;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_full     = (r_state == TX_PEND);
    assign o_ovf      = r_ovf;
    assign o_tx_valid = r_valid;
    assign o_tx_data  = r_data;
endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: MMIO decode for UART RX/TX holding registers and cycle/instruction counters
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_en,
    input  logic [31:0] mmio_addr,
    input  logic [3:0]  mmio_we,
    input  logic [31:0] mmio_wdata,
    output logic [31:0] mmio_rdata,
    input  logic        inst_retire,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);
    logic [7:0]  w_off;
    logic        w_hit;
    logic        w_ld;
    logic        w_st;
    logic        w_crst;
    logic        w_tx_full;
    logic        w_tx_ovf;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_unused;

    logic        r_rx_full;
    logic [7:0]  r_rx_byte;
    logic [31:0] r_cyc;
    logic [31:0] r_inst;
    logic [31:0] r_rdata;

    assign w_off    = mmio_addr[7:0];
    assign w_hit    = mmio_en && (mmio_addr[31:8] == BASE_ADDR[31:8]);
    assign w_ld     = w_hit && (mmio_we == 4'b0000);
    assign w_st     = w_hit && (mmio_we != 4'b0000);
    assign w_crst   = w_st && (w_off == OFF_CNT_RST);
    assign w_unused = ^mmio_wdata[31:8];

    always_comb begin
        w_status              = '0;
        w_status[ST_TX_READY] = !w_tx_full;
        w_status[ST_RX_VALID] = r_rx_full;
        w_status[ST_TX_OVF]   = w_tx_ovf;
    end

    always_comb
        w_rdata = !w_ld                    ? 32'h0 :
                  (w_off == OFF_STATUS)    ? w_status :
                  (w_off == OFF_RX_DATA)   ? {24'h0, r_rx_byte} :
                  (w_off == OFF_CYCLE_CNT) ? r_cyc :
                  (w_off == OFF_INST_CNT)  ? r_inst : 32'h0;

    // misses also update rdata (to 0) so it always reflects the latest access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'h0;
        end else if (mmio_en) begin
            r_rdata <= w_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_full <= 1'b0;
            r_rx_byte <= 8'h00;
        end else if (uart_rx_valid && !r_rx_full) begin
            r_rx_byte <= uart_rx_data;
            r_rx_full <= 1'b1;
        end else if (w_ld && w_off == OFF_RX_DATA) begin
            r_rx_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc  <= 32'h0;
            r_inst <= 32'h0;
        end else begin
            r_cyc  <= w_crst ? 32'h0 : r_cyc + 32'h1;
            r_inst <= w_crst ? 32'h0 : r_inst + {31'h0, inst_retire};
        end
    end

    mmio_tx_buf u_tx (
        .clk        (clk),
        .rst        (rst),
        .i_wr       (w_st && w_off == OFF_TX_DATA),
        .i_wdata    (mmio_wdata[7:0]),
        .i_ovf_clr  (w_ld && w_off == OFF_STATUS),
        .i_tx_ready (uart_tx_ready),
        .o_full     (w_tx_full),
        .o_ovf      (w_tx_ovf),
        .o_tx_valid (uart_tx_valid),
        .o_tx_data  (uart_tx_data)
    );

    assign mmio_rdata    = r_rdata;
    assign uart_rx_ready = !r_rx_full;
endmodule

// File: tb/tb_mmio_ctrl.sv
// tb_mmio_ctrl: directed scoreboard bench for mmio_ctrl register map, UART paths and counters
module tb_mmio_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mmio_en = 1'b0;
    logic [31:0] mmio_addr = 32'h0;
    logic [3:0]  mmio_we = 4'h0;
    logic [31:0] mmio_wdata = 32'h0;
    logic [31:0] mmio_rdata;
    logic        inst_retire = 1'b0;
    logic [7:0]  uart_rx_data = 8'h00;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;

    localparam logic [31:0] B = 32'h8000_0000;

    int n_pass = 0;
    int n_chk  = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  tx_log[$];

    mmio_ctrl #(.BASE_ADDR(B)) dut (
        .clk           (clk),
        .rst           (rst),
        .mmio_en       (mmio_en),
        .mmio_addr     (mmio_addr),
        .mmio_we       (mmio_we),
        .mmio_wdata    (mmio_wdata),
        .mmio_rdata    (mmio_rdata),
        .inst_retire   (inst_retire),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && uart_tx_valid && uart_tx_ready) tx_log.push_back(uart_tx_data);

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string n, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s obs=%h exp=%h", n, obs, exp);
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] e, input string n);
        mmio_en = 1'b1;
        mmio_addr = a;
        mmio_we = 4'h0;
        exp_q.push_back(e);
        @(negedge clk);
        mmio_en = 1'b0;
        chk(n, mmio_rdata, exp_q.pop_front());
    endtask

    task automatic st(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        mmio_en = 1'b1;
        mmio_addr = a;
        mmio_we = we;
        mmio_wdata = d;
        @(negedge clk);
        mmio_en = 1'b0;
        mmio_we = 4'h0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        chk("rst_rx_ready", {31'h0, uart_rx_ready}, 32'h1);
        chk("rst_rdata", mmio_rdata, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        ld(B + 32'h10, 32'd5, "cycle_at_5");
        ld(B + 32'h00, 32'h1, "status_idle");
        @(negedge clk);
        chk("rdata_hold", mmio_rdata, 32'h1);

        ld(32'h9000_0010, 32'h0, "miss");
        ld(B + 32'h0C, 32'h0, "unmapped");
        ld(B + 32'h08, 32'h0, "read_wo_tx");
        ld(B + 32'h18, 32'h0, "read_wo_cntrst");

        st(B + 32'h18, 4'hF, 32'h0);
        ld(B + 32'h10, 32'h0, "cycle_after_clr");
        ld(B + 32'h10, 32'h1, "cycle_inc");

        uart_rx_data = 8'h41;
        uart_rx_valid = 1'b1;
        @(negedge clk);
        uart_rx_valid = 1'b0;
        chk("rx_ready_full", {31'h0, uart_rx_ready}, 32'h0);
        ld(B + 32'h00, 32'h3, "status_rx");
        ld(B + 32'h04, 32'h41, "rx_data");
        ld(B + 32'h00, 32'h1, "status_rx_popped");
        chk("rx_ready_empty", {31'h0, uart_rx_ready}, 32'h1);
        ld(B + 32'h04, 32'h41, "rx_stale");
        chk("rx_stale_ready", {31'h0, uart_rx_ready}, 32'h1);

        uart_rx_data = 8'h11;
        uart_rx_valid = 1'b1;
        @(negedge clk);
        uart_rx_data = 8'h22;
        chk("rx_ready_pop_cycle", {31'h0, uart_rx_ready}, 32'h0);
        ld(B + 32'h04, 32'h11, "rx_pop_old");
        chk("rx_ready_after_pop", {31'h0, uart_rx_ready}, 32'h1);
        @(negedge clk);
        uart_rx_valid = 1'b0;
        chk("rx_ready_recapture", {31'h0, uart_rx_ready}, 32'h0);
        ld(B + 32'h04, 32'h22, "rx_second_byte");

        uart_tx_ready = 1'b0;
        st(B + 32'h08, 4'hF, 32'hABCD_1255);
        for (int i = 0; i < 10; i++) begin
            chk("tx_hold", {23'h0, uart_tx_valid, uart_tx_data}, 32'h155);
            @(negedge clk);
        end
        uart_tx_ready = 1'b1;
        @(negedge clk);
        uart_tx_ready = 1'b0;
        chk("tx_valid_drop", {31'h0, uart_tx_valid}, 32'h0);
        chk("tx_log_n1", tx_log.size(), 32'd1);
        chk("tx_log_b1", {24'h0, tx_log[0]}, 32'h55);

        st(B + 32'h08, 4'h1, 32'h55);
        st(B + 32'h08, 4'h1, 32'h66);
        chk("tx_held_after_ovf", {24'h0, uart_tx_data}, 32'h55);
        uart_tx_ready = 1'b1;
        @(negedge clk);
        uart_tx_ready = 1'b0;
        ld(B + 32'h00, 32'h5, "status_ovf");
        ld(B + 32'h00, 32'h1, "status_ovf_clr");
        repeat (3) @(negedge clk);
        chk("tx_log_n2", tx_log.size(), 32'd2);
        chk("tx_log_b2", {24'h0, tx_log[1]}, 32'h55);

        st(B + 32'h18, 4'hF, 32'h0);
        inst_retire = 1'b1;
        repeat (3) @(negedge clk);
        inst_retire = 1'b0;
        ld(B + 32'h14, 32'd3, "inst_3");
        inst_retire = 1'b1;
        ld(B + 32'h14, 32'd3, "inst_pre_edge");
        st(B + 32'h18, 4'h2, 32'h0);
        inst_retire = 1'b0;
        ld(B + 32'h14, 32'd0, "inst_cleared");

        st(B + 32'h08, 4'hF, 32'h77);
        chk("tx_pend_pre_rst", {31'h0, uart_tx_valid}, 32'h1);
        #2 rst = 1'b1;
        #1 chk("tx_valid_async_rst", {31'h0, uart_tx_valid}, 32'h0);
        chk("rx_ready_in_rst", {31'h0, uart_rx_ready}, 32'h1);
        chk("rdata_async_rst", mmio_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        uart_tx_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("tx_after_rst", {31'h0, uart_tx_valid}, 32'h0);
        chk("tx_log_after_rst", tx_log.size(), 32'd2);
        ld(B + 32'h00, 32'h1, "status_after_rst");
        ld(B + 32'h04, 32'h0, "rx_byte_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
